// File: rtl/weight_loader.sv
// Streams a two-layer network configuration into a shadow file and commits it atomically.
// Optional trailing checksum word is enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int FP_WIDTH   = 8,
    parameter int FP_FRAC    = 5,
    parameter int NUM_INPUTS = 9,
    parameter int HL_NEURONS = 6,
    parameter int OL_NEURONS = 3
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       START_IN,
    input  logic                                       ABORT_IN,
    input  logic [FP_WIDTH-1:0]                        DATA_IN,
    input  logic                                       DATA_VALID_IN,
    output logic                                       DATA_READY_OUT,
    output logic [HL_NEURONS*NUM_INPUTS*FP_WIDTH-1:0]  HL_WEIGHTS_OUT,
    output logic [HL_NEURONS*FP_WIDTH-1:0]             HL_BIAS_OUT,
    output logic [OL_NEURONS*HL_NEURONS*FP_WIDTH-1:0]  OL_WEIGHTS_OUT,
    output logic [OL_NEURONS*FP_WIDTH-1:0]             OL_BIAS_OUT,
    output logic                                       CFG_VALID_OUT,
    output logic                                       DONE_OUT,
    output logic                                       ERROR_OUT,
    output logic                                       BUSY_OUT
);

    localparam int HLW_WORDS   = HL_NEURONS * NUM_INPUTS;
    localparam int HLB_WORDS   = HL_NEURONS;
    localparam int OLW_WORDS   = OL_NEURONS * HL_NEURONS;
    localparam int OLB_WORDS   = OL_NEURONS;
    localparam int TOTAL_WORDS = HLW_WORDS + HLB_WORDS + OLW_WORDS + OLB_WORDS;
    localparam int CNT_W       = $clog2(TOTAL_WORDS);
    localparam int BUS_W       = TOTAL_WORDS * FP_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_WORDS - 1);

    // The fractional width is carried for downstream consumers only.
    generate
        if (FP_FRAC < 0 || FP_FRAC > FP_WIDTH) begin : g_frac_check
            $error("FP_FRAC must lie within 0..FP_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        S_CHECK  = 2'd3
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [FP_WIDTH-1:0]   r_shadow [TOTAL_WORDS];
    logic [BUS_W-1:0]      r_cfg_bus;
    logic                  r_cfg_valid;
    logic                  r_done;
    logic                  r_error;
    logic                  w_accept;
    logic                  w_write;
    logic                  w_commit;
    logic                  w_fail;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [FP_WIDTH-1:0]   r_sum;
`endif

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign DATA_READY_OUT = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
    assign DATA_READY_OUT = (r_state == S_LOAD);
`endif

    assign w_accept       = DATA_VALID_IN && DATA_READY_OUT;
    assign BUSY_OUT       = (r_state != S_IDLE);
    assign CFG_VALID_OUT  = r_cfg_valid;
    assign DONE_OUT       = r_done;
    assign ERROR_OUT      = r_error;

    // Committed buses are slices of one register so they update together.
    assign HL_WEIGHTS_OUT = r_cfg_bus[0 +: HLW_WORDS*FP_WIDTH];
    assign HL_BIAS_OUT    = r_cfg_bus[HLW_WORDS*FP_WIDTH +: HLB_WORDS*FP_WIDTH];
    assign OL_WEIGHTS_OUT = r_cfg_bus[(HLW_WORDS+HLB_WORDS)*FP_WIDTH +: OLW_WORDS*FP_WIDTH];
    assign OL_BIAS_OUT    = r_cfg_bus[(HLW_WORDS+HLB_WORDS+OLW_WORDS)*FP_WIDTH +: OLB_WORDS*FP_WIDTH];

    // Next state and per-cycle actions; abort beats a word in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (START_IN) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ABORT_IN) begin
                    w_state_nxt = S_IDLE;
                    w_fail      = 1'b1;
                end else if (w_accept) begin
                    w_write = 1'b1;
                    if (r_cnt == LAST_IDX) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_COMMIT;
`endif
                    end
                end
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (ABORT_IN) begin
                    w_state_nxt = S_IDLE;
                    w_fail      = 1'b1;
                end else if (w_accept) begin
                    if (DATA_IN == r_sum) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fail      = 1'b1;
                    end
                end
            end
`endif
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word counter restarts whenever the load is left for any reason.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_state_nxt != S_LOAD) begin
            r_cnt <= '0;
        end else if (w_write) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow file captures accepted words in stream order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TOTAL_WORDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_write) begin
            r_shadow[r_cnt] <= DATA_IN;
        end
    end

    // Copy the whole shadow file to the output buses in one edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cfg_bus <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < TOTAL_WORDS; i++) begin
                r_cfg_bus[i*FP_WIDTH +: FP_WIDTH] <= r_shadow[i];
            end
        end
    end

    // Status pulses and the sticky configuration-valid flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_done  <= w_commit;
            r_error <= w_fail;
            if (w_commit) begin
                r_cfg_valid <= 1'b1;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // Unsigned running sum of data words, wrapping at the word width.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sum <= '0;
        end else if (r_state == S_IDLE) begin
            r_sum <= '0;
        end else if (w_write) begin
            r_sum <= r_sum + DATA_IN;
        end
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Randomised self-checking bench for weight_loader against a layer-indexed reference model.
// Adds checksum scenarios when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;

    localparam int W     = 8;
    localparam int NI    = 9;
    localparam int HL    = 6;
    localparam int OL    = 3;
    localparam int TOTAL = HL*NI + HL + OL*HL + OL;
    localparam int HLW_B = HL*NI*W;
    localparam int HLB_B = HL*W;
    localparam int OLW_B = OL*HL*W;
    localparam int OLB_B = OL*W;
    localparam int ALL_B = HLW_B + HLB_B + OLW_B + OLB_B;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int SLEN  = TOTAL + 1;
`else
    localparam int SLEN  = TOTAL;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             START_IN;
    logic             ABORT_IN;
    logic [W-1:0]     DATA_IN;
    logic             DATA_VALID_IN;
    logic             DATA_READY_OUT;
    logic [HLW_B-1:0] HL_WEIGHTS_OUT;
    logic [HLB_B-1:0] HL_BIAS_OUT;
    logic [OLW_B-1:0] OL_WEIGHTS_OUT;
    logic [OLB_B-1:0] OL_BIAS_OUT;
    logic             CFG_VALID_OUT;
    logic             DONE_OUT;
    logic             ERROR_OUT;
    logic             BUSY_OUT;

    weight_loader #(
        .FP_WIDTH   (W),
        .FP_FRAC    (5),
        .NUM_INPUTS (NI),
        .HL_NEURONS (HL),
        .OL_NEURONS (OL)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START_IN       (START_IN),
        .ABORT_IN       (ABORT_IN),
        .DATA_IN        (DATA_IN),
        .DATA_VALID_IN  (DATA_VALID_IN),
        .DATA_READY_OUT (DATA_READY_OUT),
        .HL_WEIGHTS_OUT (HL_WEIGHTS_OUT),
        .HL_BIAS_OUT    (HL_BIAS_OUT),
        .OL_WEIGHTS_OUT (OL_WEIGHTS_OUT),
        .OL_BIAS_OUT    (OL_BIAS_OUT),
        .CFG_VALID_OUT  (CFG_VALID_OUT),
        .DONE_OUT       (DONE_OUT),
        .ERROR_OUT      (ERROR_OUT),
        .BUSY_OUT       (BUSY_OUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] stream [SLEN];
    logic [W-1:0] m_hw [HL][NI];
    logic [W-1:0] m_hb [HL];
    logic [W-1:0] m_ow [OL][HL];
    logic [W-1:0] m_ob [OL];
    bit           m_cfg;

    int dc, ec, dl, bl, oc;
    bit bc;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ALL_B-1:0] dut_all();
        return {OL_BIAS_OUT, OL_WEIGHTS_OUT, HL_BIAS_OUT, HL_WEIGHTS_OUT};
    endfunction

    function automatic logic [ALL_B-1:0] exp_all();
        logic [HLW_B-1:0] a;
        logic [HLB_B-1:0] b;
        logic [OLW_B-1:0] c;
        logic [OLB_B-1:0] d;
        for (int n = 0; n < HL; n++) begin
            for (int i = 0; i < NI; i++) a[(n*NI+i)*W +: W] = m_hw[n][i];
            b[n*W +: W] = m_hb[n];
        end
        for (int n = 0; n < OL; n++) begin
            for (int i = 0; i < HL; i++) c[(n*HL+i)*W +: W] = m_ow[n][i];
            d[n*W +: W] = m_ob[n];
        end
        return {d, c, b, a};
    endfunction

    // Reference: the stream maps onto layers in hidden-w, hidden-b, out-w, out-b order.
    task automatic model_commit();
        int k;
        k = 0;
        for (int n = 0; n < HL; n++)
            for (int i = 0; i < NI; i++) begin m_hw[n][i] = stream[k]; k++; end
        for (int n = 0; n < HL; n++) begin m_hb[n] = stream[k]; k++; end
        for (int n = 0; n < OL; n++)
            for (int i = 0; i < HL; i++) begin m_ow[n][i] = stream[k]; k++; end
        for (int n = 0; n < OL; n++) begin m_ob[n] = stream[k]; k++; end
        m_cfg = 1'b1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < HL; n++) begin
            for (int i = 0; i < NI; i++) m_hw[n][i] = '0;
            m_hb[n] = '0;
        end
        for (int n = 0; n < OL; n++) begin
            for (int i = 0; i < HL; i++) m_ow[n][i] = '0;
            m_ob[n] = '0;
        end
        m_cfg = 1'b0;
    endtask

    task automatic build_stream(input bit rnd);
        int s;
        s = 0;
        for (int k = 0; k < TOTAL; k++) begin
            stream[k] = rnd ? W'($urandom) : W'(k + 1);
            s = s + int'(stream[k]);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        stream[TOTAL] = W'(s % 256);
`endif
    endtask

    task automatic run_stream(
        input  int gap_pct,
        input  int start_at,
        input  int abort_at,
        input  bit abort_commit,
        output int done_cnt,
        output int err_cnt,
        output int done_lat,
        output int busy_low,
        output bit busy_commit,
        output int out_changes
    );
        logic [ALL_B-1:0] snap;
        int idx, cyc;
        bit v, aborted;
        done_cnt = 0; err_cnt = 0; done_lat = -1;
        busy_low = 0; busy_commit = 0; out_changes = 0;
        idx = 0; cyc = 0; aborted = 0;
        snap = dut_all();
        DATA_VALID_IN = 0; ABORT_IN = 0; START_IN = 1;
        tick();
        START_IN = 0;
        while (!aborted && idx < SLEN && cyc < 20000) begin
            v = ($urandom_range(99) >= gap_pct);
            DATA_VALID_IN = v;
            DATA_IN = v ? stream[idx] : W'($urandom);
            START_IN = (idx == start_at);
            ABORT_IN = v && (idx == abort_at);
            if (!BUSY_OUT || !DATA_READY_OUT) busy_low++;
            if (dut_all() !== snap) out_changes++;
            if (DONE_OUT) done_cnt++;
            if (ERROR_OUT) err_cnt++;
            tick();
            cyc++;
            if (v) begin
                if (idx == abort_at) aborted = 1;
                else idx++;
            end
        end
        DATA_VALID_IN = 0; START_IN = 0; ABORT_IN = abort_commit;
        checks++;
        if (!aborted && idx < SLEN) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d words, required %0d", idx, SLEN);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                busy_commit = BUSY_OUT;
                if (dut_all() !== snap) out_changes++;
            end
            if (DONE_OUT) begin
                done_cnt++;
                if (done_lat < 0) done_lat = k;
            end
            if (ERROR_OUT) err_cnt++;
            tick();
            ABORT_IN = 0;
        end
    endtask

    task automatic test_reset();
        RST = 1; START_IN = 0; ABORT_IN = 0; DATA_IN = '0; DATA_VALID_IN = 0;
        model_reset();
        repeat (2) tick();
        checks++;
        if (dut_all() !== '0) begin
            errors++; $display("FAIL reset_buses: got %h required 0", dut_all());
        end
        checks++;
        if ({CFG_VALID_OUT, DONE_OUT, ERROR_OUT, BUSY_OUT, DATA_READY_OUT} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {CFG_VALID_OUT, DONE_OUT, ERROR_OUT, BUSY_OUT, DATA_READY_OUT});
        end
        RST = 0;
        DATA_VALID_IN = 1; DATA_IN = 8'h5A;
        tick();
        checks++;
        if ({BUSY_OUT, DATA_READY_OUT} !== 2'b00) begin
            errors++; $display("FAIL idle_ready: got %b required 00", {BUSY_OUT, DATA_READY_OUT});
        end
        DATA_VALID_IN = 0;
        tick();
    endtask

    task automatic test_sequential_load();
        build_stream(0);
        run_stream(0, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || ec !== 0) begin
            errors++; $display("FAIL seq_pulses: done=%0d err=%0d required 1,0", dc, ec);
        end
        checks++;
        if (dl !== 1) begin
            errors++; $display("FAIL seq_latency: got %0d required 1", dl);
        end
        checks++;
        if (bl !== 0 || bc !== 1'b1) begin
            errors++; $display("FAIL seq_busy: low=%0d commit=%0b required 0,1", bl, bc);
        end
        checks++;
        if (oc !== 0) begin
            errors++; $display("FAIL seq_atomic: early changes %0d required 0", oc);
        end
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL seq_buses: got %h required %h", dut_all(), exp_all());
        end
        checks++;
        if (HL_WEIGHTS_OUT[0 +: W] !== 8'd1 || HL_WEIGHTS_OUT[53*W +: W] !== 8'd54) begin
            errors++;
            $display("FAIL seq_hw_words: got %0d,%0d required 1,54",
                     HL_WEIGHTS_OUT[0 +: W], HL_WEIGHTS_OUT[53*W +: W]);
        end
        checks++;
        if (HL_BIAS_OUT[5*W +: W] !== 8'd60 || OL_BIAS_OUT[2*W +: W] !== 8'd81) begin
            errors++;
            $display("FAIL seq_bias_words: got %0d,%0d required 60,81",
                     HL_BIAS_OUT[5*W +: W], OL_BIAS_OUT[2*W +: W]);
        end
        checks++;
        if (CFG_VALID_OUT !== m_cfg) begin
            errors++; $display("FAIL seq_cfg_valid: got %b required %b", CFG_VALID_OUT, m_cfg);
        end
    endtask

    task automatic test_gaps_start();
        build_stream(1);
        run_stream(40, 20, -1, 1, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || ec !== 0 || dl !== 1) begin
            errors++;
            $display("FAIL gaps_pulses: done=%0d err=%0d lat=%0d required 1,0,1", dc, ec, dl);
        end
        checks++;
        if (bl !== 0 || bc !== 1'b1) begin
            errors++; $display("FAIL gaps_busy: low=%0d commit=%0b required 0,1", bl, bc);
        end
        checks++;
        if (oc !== 0) begin
            errors++; $display("FAIL gaps_atomic: early changes %0d required 0", oc);
        end
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL gaps_buses: got %h required %h", dut_all(), exp_all());
        end
    endtask

    task automatic test_abort();
        build_stream(1);
        run_stream(30, -1, 40, 0, dc, ec, dl, bl, bc, oc);
        checks++;
        if (ec !== 1 || dc !== 0) begin
            errors++; $display("FAIL abort_pulses: err=%0d done=%0d required 1,0", ec, dc);
        end
        checks++;
        if (dut_all() !== exp_all() || CFG_VALID_OUT !== m_cfg) begin
            errors++;
            $display("FAIL abort_keep: got %h cfg=%b required %h cfg=%b",
                     dut_all(), CFG_VALID_OUT, exp_all(), m_cfg);
        end
        checks++;
        if (BUSY_OUT !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b required 0", BUSY_OUT);
        end
        build_stream(1);
        run_stream(20, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || dut_all() !== exp_all()) begin
            errors++;
            $display("FAIL abort_reload: done=%0d got %h required 1 %h", dc, dut_all(), exp_all());
        end
    endtask

    task automatic test_idle_controls();
        ABORT_IN = 1; DATA_VALID_IN = 1; DATA_IN = 8'hC3;
        tick();
        checks++;
        if ({ERROR_OUT, BUSY_OUT, DATA_READY_OUT} !== 3'b000) begin
            errors++;
            $display("FAIL idle_abort: got %b required 000", {ERROR_OUT, BUSY_OUT, DATA_READY_OUT});
        end
        DATA_VALID_IN = 0; START_IN = 1; ABORT_IN = 1;
        tick();
        START_IN = 0; ABORT_IN = 0;
        checks++;
        if ({BUSY_OUT, ERROR_OUT} !== 2'b10) begin
            errors++; $display("FAIL start_abort: got %b required 10", {BUSY_OUT, ERROR_OUT});
        end
        build_stream(1);
        run_stream(10, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || ec !== 0 || dut_all() !== exp_all()) begin
            errors++;
            $display("FAIL start_abort_load: done=%0d err=%0d got %h required %h",
                     dc, ec, dut_all(), exp_all());
        end
    endtask

    task automatic test_stall();
        build_stream(1);
        run_stream(95, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (bl !== 0 || oc !== 0) begin
            errors++; $display("FAIL stall_hold: low=%0d changes=%0d required 0,0", bl, oc);
        end
        checks++;
        if (dc !== 1 || dut_all() !== exp_all()) begin
            errors++;
            $display("FAIL stall_load: done=%0d got %h required %h", dc, dut_all(), exp_all());
        end
    endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        build_stream(0);
        stream[TOTAL] = 8'h11;
        run_stream(0, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        checks++;
        if (ec !== 1 || dc !== 0) begin
            errors++; $display("FAIL cksum_bad: err=%0d done=%0d required 1,0", ec, dc);
        end
        checks++;
        if (dut_all() !== exp_all() || CFG_VALID_OUT !== m_cfg) begin
            errors++; $display("FAIL cksum_keep: got %h required %h", dut_all(), exp_all());
        end
        stream[TOTAL] = 8'hF9;
        run_stream(0, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || ec !== 0 || dut_all() !== exp_all()) begin
            errors++;
            $display("FAIL cksum_good: done=%0d err=%0d got %h required %h",
                     dc, ec, dut_all(), exp_all());
        end
    endtask
`endif

    task automatic test_reset_mid();
        build_stream(1);
        START_IN = 1;
        tick();
        START_IN = 0;
        for (int k = 0; k < 30; k++) begin
            DATA_VALID_IN = 1; DATA_IN = stream[k];
            tick();
        end
        #1 RST = 1;
        DATA_VALID_IN = 0;
        model_reset();
        #1;
        checks++;
        if (dut_all() !== exp_all()) begin
            errors++; $display("FAIL rst_mid_buses: got %h required 0", dut_all());
        end
        checks++;
        if ({CFG_VALID_OUT, DONE_OUT, ERROR_OUT, BUSY_OUT, DATA_READY_OUT} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: got %b required 00000",
                     {CFG_VALID_OUT, DONE_OUT, ERROR_OUT, BUSY_OUT, DATA_READY_OUT});
        end
        tick();
        RST = 0;
        tick();
        build_stream(0);
        run_stream(0, -1, -1, 0, dc, ec, dl, bl, bc, oc);
        model_commit();
        checks++;
        if (dc !== 1 || dut_all() !== exp_all() || CFG_VALID_OUT !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reload: done=%0d cfg=%b got %h required %h",
                     dc, CFG_VALID_OUT, dut_all(), exp_all());
        end
    endtask

    initial begin
        test_reset();
        test_sequential_load();
        test_gaps_start();
        test_abort();
        test_idle_controls();
        test_stall();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
